// File: rtl/lab5_mcore_mem_refill_arbiter_pkg.sv
// rtl/lab5_mcore_mem_refill_arbiter_pkg.sv - shared port ids and 16B memory message types
package lab5_mcore_arb_pkg;

  typedef logic [0:0] port_id_t;

  localparam port_id_t PORT_ICACHE = 1'b0;
  localparam port_id_t PORT_DCACHE = 1'b1;

  // Field layout matches the course memory message library (175b request / 145b response).
  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

// File: rtl/lab5_mcore_mem_refill_arbiter_if.sv
// rtl/lab5_mcore_mem_refill_arbiter_if.sv - cache-side and memory-side val/rdy bundle of the refill arbiter
interface lab5_mcore_mem_refill_arbiter_if;
  import lab5_mcore_arb_pkg::*;

  mem_req_16B_t  req0_msg;
  logic          req0_val;
  logic          req0_rdy;
  mem_resp_16B_t resp0_msg;
  logic          resp0_val;
  logic          resp0_rdy;

  mem_req_16B_t  req1_msg;
  logic          req1_val;
  logic          req1_rdy;
  mem_resp_16B_t resp1_msg;
  logic          resp1_val;
  logic          resp1_rdy;

  mem_req_16B_t  memreq_msg;
  logic          memreq_val;
  logic          memreq_rdy;
  mem_resp_16B_t memresp_msg;
  logic          memresp_val;
  logic          memresp_rdy;

  logic          conflict;

  modport master (
    input  req0_msg, req0_val, resp0_rdy,
    output req0_rdy, resp0_msg, resp0_val,
    input  req1_msg, req1_val, resp1_rdy,
    output req1_rdy, resp1_msg, resp1_val,
    output memreq_msg, memreq_val, memresp_rdy, conflict,
    input  memreq_rdy, memresp_msg, memresp_val
  );

  modport slave (
    output req0_msg, req0_val, resp0_rdy,
    input  req0_rdy, resp0_msg, resp0_val,
    output req1_msg, req1_val, resp1_rdy,
    input  req1_rdy, resp1_msg, resp1_val,
    input  memreq_msg, memreq_val, memresp_rdy, conflict,
    output memreq_rdy, memresp_msg, memresp_val
  );

endinterface

// File: rtl/lab5_mcore_mem_refill_arbiter_src_id_queue.sv
// rtl/lab5_mcore_mem_refill_arbiter_src_id_queue.sv - FIFO of source port ids for in-flight memory requests
module lab5_mcore_src_id_queue
  import lab5_mcore_arb_pkg::*;
#(
  parameter int p_depth = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  output port_id_t head_id,
  output logic     empty,
  output logic     full
);

  localparam int PW = $clog2(p_depth);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  port_id_t      mem_q [p_depth];

  logic do_push;
  logic do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(p_depth));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    // Push and pop together leave the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/lab5_mcore_mem_refill_arbiter.sv
// rtl/lab5_mcore_mem_refill_arbiter.sv - round-robin share of one 16B memory port between icache and dcache
module lab5_mcore_mem_refill_arbiter
  import lab5_mcore_arb_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input logic                           clk,
  input logic                           reset,
  lab5_mcore_mem_refill_arbiter_if.master bus
);

  port_id_t rr_last_q, rr_last_d;
  port_id_t grant_id;
  port_id_t head_id;

  logic q_full, q_empty;
  logic elig0, elig1;
  logic memreq_val_w, memresp_rdy_w;
  logic fire_req, fire_resp;
  logic head_live;

  lab5_mcore_src_id_queue #(
    .p_depth (p_max_outstanding)
  ) u_src_q (
    .clk     (clk),
    .reset   (reset),
    .push    (fire_req),
    .push_id (grant_id),
    .pop     (fire_resp),
    .head_id (head_id),
    .empty   (q_empty),
    .full    (q_full)
  );

  // Eligibility uses only the registered full flag, so a same-cycle pop cannot reach req_rdy.
  always_comb begin
    elig0 = bus.req0_val & ~q_full;
    elig1 = bus.req1_val & ~q_full;
    if (elig0 & elig1)  grant_id = ~rr_last_q;
    else if (elig1)     grant_id = PORT_DCACHE;
    else                grant_id = PORT_ICACHE;
  end

  assign memreq_val_w   = reset & (elig0 | elig1);
  assign fire_req       = memreq_val_w & bus.memreq_rdy;
  assign bus.memreq_val = memreq_val_w;
  assign bus.memreq_msg = (grant_id == PORT_DCACHE) ? bus.req1_msg : bus.req0_msg;
  assign bus.req0_rdy   = reset & elig0 & (grant_id == PORT_ICACHE) & bus.memreq_rdy;
  assign bus.req1_rdy   = reset & elig1 & (grant_id == PORT_DCACHE) & bus.memreq_rdy;
  assign bus.conflict   = bus.req0_val & bus.req1_val & fire_req;

  // Responses come back in request order, so the queue head names their owner.
  assign head_live       = reset & ~q_empty;
  assign memresp_rdy_w   = head_live &
                           ((head_id == PORT_DCACHE) ? bus.resp1_rdy : bus.resp0_rdy);
  assign fire_resp       = bus.memresp_val & memresp_rdy_w;
  assign bus.memresp_rdy = memresp_rdy_w;
  assign bus.resp0_val   = head_live & bus.memresp_val & (head_id == PORT_ICACHE);
  assign bus.resp1_val   = head_live & bus.memresp_val & (head_id == PORT_DCACHE);
  assign bus.resp0_msg   = bus.memresp_msg;
  assign bus.resp1_msg   = bus.memresp_msg;

  always_comb begin
    rr_last_d = rr_last_q;
    if (fire_req) rr_last_d = grant_id;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_last_q <= PORT_DCACHE;
    else        rr_last_q <= rr_last_d;
  end

endmodule

// File: tb/tb_lab5_mcore_mem_refill_arbiter.sv
// tb/tb_lab5_mcore_mem_refill_arbiter.sv - directed bench with a queue-based reference model of the refill arbiter
module tb_lab5_mcore_mem_refill_arbiter;
  import lab5_mcore_arb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lab5_mcore_mem_refill_arbiter_if bus();

  lab5_mcore_mem_refill_arbiter #(.p_max_outstanding(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  mem_req_16B_t  r0_msg, r1_msg;
  mem_resp_16B_t mr_msg;
  logic r0_val, r1_val, s0_rdy, s1_rdy, mq_rdy, mr_val;

  assign bus.req0_msg    = r0_msg;
  assign bus.req0_val    = r0_val;
  assign bus.resp0_rdy   = s0_rdy;
  assign bus.req1_msg    = r1_msg;
  assign bus.req1_val    = r1_val;
  assign bus.resp1_rdy   = s1_rdy;
  assign bus.memreq_rdy  = mq_rdy;
  assign bus.memresp_msg = mr_msg;
  assign bus.memresp_val = mr_val;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_rr_last = 1'b1;
  bit m_q[$];
  bit x_in_reset, x_fire_req, x_fire_resp, x_grant;

  function automatic mem_req_16B_t mk_req(logic [7:0] opq, logic [31:0] addr, logic [127:0] data);
    mem_req_16B_t m;
    m.type_ = 3'd0; m.opaque = opq; m.addr = addr; m.len = 4'd0; m.data = data;
    return m;
  endfunction

  function automatic mem_resp_16B_t mk_resp(logic [7:0] opq, logic [127:0] data);
    mem_resp_16B_t m;
    m.type_ = 3'd0; m.opaque = opq; m.test = 2'd0; m.len = 4'd0; m.data = data;
    return m;
  endfunction

  task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a list of owners of outstanding requests plus who won the last grant.
  task automatic cyc_begin();
    bit full, empty, e0, e1, mv, head, mrr;
    mem_req_16B_t xm;
    @(negedge clk);
    x_in_reset  = !rst_n;
    full        = (m_q.size() == DEPTH);
    empty       = (m_q.size() == 0);
    e0          = r0_val && !full;
    e1          = r1_val && !full;
    x_grant     = (e0 && e1) ? !m_rr_last : e1;
    mv          = (e0 || e1) && !x_in_reset;
    x_fire_req  = mv && mq_rdy;
    head        = empty ? 1'b0 : m_q[0];
    mrr         = !empty && !x_in_reset && (head ? s1_rdy : s0_rdy);
    x_fire_resp = mr_val && mrr;
    xm          = x_grant ? r1_msg : r0_msg;
    chk1("memreq_val", bus.memreq_val, mv);
    chk1("req0_rdy", bus.req0_rdy, x_fire_req && !x_grant);
    chk1("req1_rdy", bus.req1_rdy, x_fire_req && x_grant);
    chk1("conflict", bus.conflict, r0_val && r1_val && x_fire_req);
    chk1("memresp_rdy", bus.memresp_rdy, mrr);
    chk1("resp0_val", bus.resp0_val, mr_val && !empty && !x_in_reset && !head);
    chk1("resp1_val", bus.resp1_val, mr_val && !empty && !x_in_reset && head);
    chk("resp0_msg", 192'(bus.resp0_msg), 192'(mr_msg));
    chk("resp1_msg", 192'(bus.resp1_msg), 192'(mr_msg));
    if (mv) chk("memreq_msg", 192'(bus.memreq_msg), 192'(xm));
  endtask

  task automatic cyc_end();
    @(posedge clk);
    if (!x_in_reset) begin
      if (x_fire_resp) void'(m_q.pop_front());
      if (x_fire_req) begin
        m_q.push_back(x_grant);
        m_rr_last = x_grant;
      end
    end
    #1;
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr_last = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  task automatic idle();
    r0_val = 0; r1_val = 0; mr_val = 0;
  endtask

  initial begin
    r0_msg = mk_req(8'h00, 32'h0, 128'h0);
    r1_msg = mk_req(8'h00, 32'h0, 128'h0);
    mr_msg = mk_resp(8'h00, 128'h0);
    r0_val = 1; r1_val = 1; mr_val = 1;
    s0_rdy = 1; s1_rdy = 1; mq_rdy = 1;

    // Reset state: everything quiet even with every input asserting.
    cyc_begin();
    chk1("rst_memreq_val", bus.memreq_val, 1'b0);
    chk1("rst_req0_rdy", bus.req0_rdy, 1'b0);
    chk1("rst_memresp_rdy", bus.memresp_rdy, 1'b0);
    cyc_end();
    step();
    idle();
    rst_n = 1'b1;
    step();

    // 1: single icache read at 0x1000, response two cycles later.
    r0_msg = mk_req(8'h11, 32'h0000_1000, 128'h0);
    r0_val = 1;
    cyc_begin();
    chk1("t1_req0_rdy", bus.req0_rdy, 1'b1);
    chk("t1_memreq_addr", 192'(bus.memreq_msg.addr), 192'(32'h0000_1000));
    chk1("t1_resp1_val", bus.resp1_val, 1'b0);
    cyc_end();
    r0_val = 0;
    step();
    step();
    mr_msg = mk_resp(8'h11, 128'hCAFE_0001);
    mr_val = 1;
    cyc_begin();
    chk1("t1_resp0_val", bus.resp0_val, 1'b1);
    chk1("t1_resp1_val_rsp", bus.resp1_val, 1'b0);
    chk("t1_resp0_data", 192'(bus.resp0_msg.data), 192'(128'hCAFE_0001));
    cyc_end();
    idle();
    step();

    // 2: contention for four cycles after a fresh reset.
    pulse_reset();
    r0_msg = mk_req(8'hA0, 32'h0000_2000, 128'hA);
    r1_msg = mk_req(8'hB0, 32'h0000_3000, 128'hB);
    r0_val = 1; r1_val = 1;
    for (int i = 0; i < 4; i++) begin
      cyc_begin();
      chk("t2_grant", 192'(bus.memreq_msg.opaque), 192'((i % 2 == 1) ? 8'hB0 : 8'hA0));
      chk1("t2_conflict", bus.conflict, 1'b1);
      cyc_end();
    end
    idle();
    mr_val = 1;
    for (int i = 0; i < 4; i++) begin
      mr_msg = mk_resp(8'(i), 128'(i + 100));
      cyc_begin();
      chk1("t2_route", (i % 2 == 1) ? bus.resp1_val : bus.resp0_val, 1'b1);
      chk1("t2_route_other", (i % 2 == 1) ? bus.resp0_val : bus.resp1_val, 1'b0);
      cyc_end();
    end
    idle();
    step();

    // 3: dcache streams until the id queue is full, then one response frees a slot.
    r1_val = 1;
    for (int i = 0; i < 4; i++) begin
      cyc_begin();
      chk1("t3_rdy_fill", bus.req1_rdy, 1'b1);
      cyc_end();
    end
    for (int i = 0; i < 2; i++) begin
      cyc_begin();
      chk1("t3_rdy_full", bus.req1_rdy, 1'b0);
      chk1("t3_val_full", bus.memreq_val, 1'b0);
      cyc_end();
    end
    mr_val = 1;
    cyc_begin();
    chk1("t3_pop", bus.memresp_rdy, 1'b1);
    chk1("t3_no_grant_on_pop", bus.req1_rdy, 1'b0);
    cyc_end();
    mr_val = 0;
    cyc_begin();
    chk1("t3_rdy_after_pop", bus.req1_rdy, 1'b1);
    cyc_end();
    idle();
    mr_val = 1;
    for (int i = 0; i < 4; i++) step();
    idle();

    // 4: head owner stalls, later dcache response waits behind it.
    r0_val = 1; step();
    r0_val = 0; r1_val = 1; step();
    idle();
    mr_val = 1; s0_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cyc_begin();
      chk1("t4_stall_rdy", bus.memresp_rdy, 1'b0);
      chk1("t4_stall_r1", bus.resp1_val, 1'b0);
      chk1("t4_stall_r0", bus.resp0_val, 1'b1);
      cyc_end();
    end
    s0_rdy = 1;
    cyc_begin();
    chk1("t4_drain0", bus.resp0_val, 1'b1);
    chk1("t4_drain0_rdy", bus.memresp_rdy, 1'b1);
    cyc_end();
    cyc_begin();
    chk1("t4_drain1", bus.resp1_val, 1'b1);
    cyc_end();
    idle();

    // 5: push and pop in the same cycle at two outstanding.
    r0_val = 1; step();
    r0_val = 0; r1_val = 1; step();
    r1_val = 0; r0_val = 1; mr_val = 1;
    cyc_begin();
    chk1("t5_push", bus.req0_rdy, 1'b1);
    chk1("t5_pop", bus.memresp_rdy, 1'b1);
    cyc_end();
    chk("t5_depth", 192'(m_q.size()), 192'(2));
    r0_val = 0;
    cyc_begin();
    chk1("t5_head_adv", bus.resp1_val, 1'b1);
    cyc_end();
    cyc_begin();
    chk1("t5_tail", bus.resp0_val, 1'b1);
    cyc_end();
    idle();
    step();

    // 6: asynchronous reset with three requests in flight.
    r0_val = 1; step();
    r0_val = 0; r1_val = 1; step();
    r1_val = 0; r0_val = 1; step();
    r0_val = 1; r1_val = 1; mr_val = 1; s0_rdy = 1; s1_rdy = 1;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("t6_req0_rdy", bus.req0_rdy, 1'b0);
    chk1("t6_req1_rdy", bus.req1_rdy, 1'b0);
    chk1("t6_memreq_val", bus.memreq_val, 1'b0);
    chk1("t6_memresp_rdy", bus.memresp_rdy, 1'b0);
    chk1("t6_resp0_val", bus.resp0_val, 1'b0);
    chk1("t6_resp1_val", bus.resp1_val, 1'b0);
    model_reset();
    step();
    rst_n = 1'b1;
    cyc_begin();
    chk("t6_first_grant", 192'(bus.memreq_msg.opaque), 192'(r0_msg.opaque));
    chk1("t6_empty_rdy", bus.memresp_rdy, 1'b0);
    chk1("t6_empty_val", bus.resp0_val, 1'b0);
    cyc_end();
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
